// File: rtl/onehot_decoder_seq.sv
// Sequenced 3-to-8 decoder: drains a small FIFO of {code, hold} entries and
// drives the matching one-hot line for the requested number of enabled cycles.
module onehot_decoder_seq #(
   parameter int DEPTH  = 4,
   parameter int HOLD_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_code,
   input  logic [HOLD_W-1:0]        in_hold,
   input  logic                     e,
   output logic [7:0]               y,
   output logic                     y_valid,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 3 + HOLD_W;

   typedef enum logic {IDLE, DRIVE} state_t;

   state_t            state, state_nxt;
   logic [EW-1:0]     mem [DEPTH];
   logic [AW-1:0]     wptr, rptr;
   logic [HOLD_W-1:0] rem, rem_nxt;
   logic [2:0]        cur, cur_nxt;
   logic [7:0]        y_nxt;
   logic              push, pop, load;
   logic [2:0]        head_code;
   logic [HOLD_W-1:0] head_hold;

   function automatic logic [7:0] decode(input logic [2:0] c);
      decode = 8'd1 << c;
   endfunction

   // Cycles left after the first asserted one; a hold of 0 behaves as 1.
   function automatic logic [HOLD_W-1:0] first_rem(input logic [HOLD_W-1:0] h);
      first_rem = (h == '0) ? '0 : h - HOLD_W'(1);
   endfunction

   assign in_ready               = (count < CW'(DEPTH));
   assign push                   = in_valid && in_ready;
   assign {head_code, head_hold} = mem[rptr];

   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      cur_nxt   = cur;
      y_nxt     = '0;
      load      = 1'b0;
      pop       = 1'b0;
      if (state == IDLE) begin
         load = (count != '0) && !e;
      end else if (!e) begin
         if (rem != '0) begin
            rem_nxt = rem - HOLD_W'(1);
            y_nxt   = decode(cur);
         end else if (count != '0) begin
            load = 1'b1;
         end else begin
            state_nxt = IDLE;
         end
      end
      // Popping the head and loading it share one path so strobes chain without gaps.
      if (load) begin
         pop       = 1'b1;
         cur_nxt   = head_code;
         rem_nxt   = first_rem(head_hold);
         y_nxt     = decode(head_code);
         state_nxt = DRIVE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rem     <= '0;
         cur     <= '0;
         y       <= '0;
         y_valid <= 1'b0;
         busy    <= 1'b0;
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
      end else begin
         state   <= state_nxt;
         rem     <= rem_nxt;
         cur     <= cur_nxt;
         y       <= y_nxt;
         y_valid <= |y_nxt;
         busy    <= (state_nxt == DRIVE);
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; the pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= {in_code, in_hold};
   end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Scoreboard bench for onehot_decoder_seq: accepted pushes queue expected
// strobes; a negedge monitor checks every output cycle against them.
module tb_onehot_decoder_seq;

   localparam int DEPTH  = 4;
   localparam int HOLD_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_code;
   logic [HOLD_W-1:0] in_hold;
   logic              e;
   logic [7:0]        y;
   logic              y_valid;
   logic              busy;
   logic [$clog2(DEPTH):0] count;

   onehot_decoder_seq #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_code(in_code), .in_hold(in_hold), .e(e), .y(y),
      .y_valid(y_valid), .busy(busy), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] code;
      int         hold;
      int         pcyc;
   } ent_t;

   ent_t       exp_q[$];
   int         cyc = 0;
   int         cur_left = 0;
   logic [7:0] cur_y = '0;
   logic       e_q = 1'b0;
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string name, input bit ok, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: a push is accepted when fewer than DEPTH entries await decoding.
   always @(posedge clk) begin
      cyc++;
      e_q = e;
      if (!rst && in_valid && exp_q.size() < DEPTH) begin
         ent_t n;
         n.code = in_code;
         n.hold = (in_hold == '0) ? 1 : int'(in_hold);
         n.pcyc = cyc;
         exp_q.push_back(n);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("y_valid", y_valid == (y != 8'd0), int'(y_valid), int'(y != 8'd0));
         chk("onehot", (y == 8'd0) || $onehot(y), int'(y), 0);
         if (e_q) chk("disable_y", y == 8'd0, int'(y), 0);
         if (y != 8'd0) begin
            chk("busy_drive", busy == 1'b1, int'(busy), 1);
            if (cur_left == 0) begin
               chk("unexpected_strobe", exp_q.size() != 0, int'(y), 0);
               if (exp_q.size() != 0) begin
                  chk("fall_through", exp_q[0].pcyc < cyc, exp_q[0].pcyc, cyc - 1);
                  cur_y    = 8'd1 << exp_q[0].code;
                  cur_left = exp_q[0].hold;
                  void'(exp_q.pop_front());
               end
            end
            chk("strobe_code", y == cur_y, int'(y), int'(cur_y));
            if (cur_left > 0) cur_left--;
         end else if (!e_q) begin
            chk("truncated", cur_left == 0, cur_left, 0);
            chk("gap", !(exp_q.size() != 0 && exp_q[0].pcyc < cyc), int'(y), 1);
            chk("busy_idle", busy == 1'b0, int'(busy), 0);
         end else if (cur_left > 0) begin
            chk("pause_busy", busy == 1'b1, int'(busy), 1);
         end
         chk("count", int'(count) == exp_q.size(), int'(count), exp_q.size());
         chk("in_ready", in_ready == (exp_q.size() < DEPTH), int'(in_ready), int'(exp_q.size() < DEPTH));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] c, input logic [HOLD_W-1:0] h);
      in_valid = 1'b1;
      in_code  = c;
      in_hold  = h;
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 600 && (exp_q.size() != 0 || cur_left != 0); i++) step();
      chk("drain_timeout", exp_q.size() == 0 && cur_left == 0, exp_q.size() + cur_left, 0);
      step();
      step();
   endtask

   task automatic check_reset_values();
      chk("rst_y", y == 8'd0, int'(y), 0);
      chk("rst_y_valid", y_valid == 1'b0, int'(y_valid), 0);
      chk("rst_busy", busy == 1'b0, int'(busy), 0);
      chk("rst_count", count == '0, int'(count), 0);
      chk("rst_in_ready", in_ready == 1'b1, int'(in_ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; e = 1'b0; in_valid = 1'b0; in_code = '0; in_hold = '0;
      #2 rst = 1'b1;
      #1 check_reset_values();
      step(); step();
      rst = 1'b0;
      step();

      push(3'd5, 4'd3);
      drain();

      push(3'd0, 4'd1); push(3'd7, 4'd2); push(3'd3, 4'd0);
      drain();

      e = 1'b1;
      for (int i = 0; i < DEPTH; i++) push(3'(i + 1), 4'(i + 1));
      chk("full_ready", in_ready == 1'b0 && int'(count) == DEPTH, int'(count), DEPTH);
      push(3'd6, 4'd2);
      step();
      e = 1'b0;
      drain();

      push(3'd2, 4'd4);
      step();
      e = 1'b1;
      step(); step();
      e = 1'b0;
      drain();

      push(3'd1, 4'd8); push(3'd4, 4'd2); push(3'd6, 4'd2);
      step();
      #2 rst = 1'b1;
      #1 check_reset_values();
      exp_q.delete();
      cur_left = 0;
      step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) step();

      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 2) == 0);
         in_code  = 3'($urandom_range(0, 7));
         in_hold  = ($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         if ($urandom_range(0, 9) == 0) e = ~e;
         step();
      end
      in_valid = 1'b0;
      e = 1'b0;
      drain();
      chk("end_idle", busy == 1'b0 && count == '0, int'(busy) + int'(count), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
